// File: rtl/alu_mc.sv
// Multi-cycle execute ALU. Single-cycle ops finish at the accept edge.
// MUL/MULH/MULHU and DIV/REM run through a radix-2 iterative datapath.
//
// state | meaning
// IDLE  | waiting for an op; single-cycle ops complete here
// MUL   | shift-add multiply, WIDTH iterations
// DIV   | restoring divide, WIDTH iterations
// FIX   | sign correction and half select, result loaded
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_src0,
    input  logic [WIDTH-1:0] alu_src1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [4:0] OP_ADD   = 5'b00000, OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_SLT   = 5'b00100, OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_AND   = 5'b01001, OP_OR    = 5'b01010;
    localparam logic [4:0] OP_XOR   = 5'b01011, OP_SLL   = 5'b01110;
    localparam logic [4:0] OP_SRL   = 5'b01111, OP_SRA   = 5'b10000;
    localparam logic [4:0] OP_SRC0  = 5'b10001, OP_SRC1  = 5'b10010;
    localparam logic [4:0] OP_MUL   = 5'b10100, OP_MULH  = 5'b10101;
    localparam logic [4:0] OP_MULHU = 5'b10110, OP_DIV   = 5'b11000;
    localparam logic [4:0] OP_DIVU  = 5'b11001, OP_REM   = 5'b11010;
    localparam logic [4:0] OP_REMU  = 5'b11011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [4:0]       op_q;
    logic             neg_q;

    logic             signed_op, s0_neg, s1_neg, div0, ovf, neg_next;
    logic             iter_mul, iter_div;
    logic [WIDTH-1:0] s0_mag, s1_mag, res_comb, fix_res, mulh_neg_hi;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [SHW-1:0]   shamt;

    assign shamt     = alu_src1[SHW-1:0];
    assign signed_op = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign s0_neg    = signed_op && alu_src0[WIDTH-1];
    assign s1_neg    = signed_op && alu_src1[WIDTH-1];
    assign s0_mag    = s0_neg ? -alu_src0 : alu_src0;
    assign s1_mag    = s1_neg ? -alu_src1 : alu_src1;
    assign neg_next  = (alu_op == OP_REM) ? s0_neg : (s0_neg ^ s1_neg);
    assign div0      = (alu_src1 == '0);
    assign ovf       = (alu_src0 == {1'b1, {(WIDTH-1){1'b0}}}) && (alu_src1 == '1);

    always_comb begin
        res_comb = '0;
        iter_mul = 1'b0;
        iter_div = 1'b0;
        case (alu_op)
            OP_ADD:  res_comb = alu_src0 + alu_src1;
            OP_SUB:  res_comb = alu_src0 - alu_src1;
            OP_SLT:  res_comb = {{(WIDTH-1){1'b0}}, $signed(alu_src0) < $signed(alu_src1)};
            OP_SLTU: res_comb = {{(WIDTH-1){1'b0}}, alu_src0 < alu_src1};
            OP_AND:  res_comb = alu_src0 & alu_src1;
            OP_OR:   res_comb = alu_src0 | alu_src1;
            OP_XOR:  res_comb = alu_src0 ^ alu_src1;
            OP_SLL:  res_comb = alu_src0 << shamt;
            OP_SRL:  res_comb = alu_src0 >> shamt;
            OP_SRA:  res_comb = $unsigned($signed(alu_src0) >>> shamt);
            OP_SRC0: res_comb = alu_src0;
            OP_SRC1: res_comb = alu_src1;
            OP_MUL, OP_MULH, OP_MULHU: iter_mul = 1'b1;
            OP_DIV: begin
                if (div0)     res_comb = '1;
                else if (ovf) res_comb = alu_src0;
                else          iter_div = 1'b1;
            end
            OP_DIVU: begin
                if (div0) res_comb = '1;
                else      iter_div = 1'b1;
            end
            OP_REM: begin
                if (div0)     res_comb = alu_src0;
                else if (ovf) res_comb = '0;
                else          iter_div = 1'b1;
            end
            OP_REMU: begin
                if (div0) res_comb = alu_src0;
                else      iter_div = 1'b1;
            end
            default: res_comb = '0;
        endcase
    end

    // Multiply: {acc_hi, acc_lo} is the product register, multiplier shifts out of acc_lo.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    // High half of the negated 2*WIDTH product: carry into it only when the low half is zero.
    assign mulh_neg_hi = ~acc_hi + {{(WIDTH-1){1'b0}}, (acc_lo == '0)};

    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:           fix_res = acc_lo;
            OP_MULH:          fix_res = neg_q ? mulh_neg_hi : acc_hi;
            OP_MULHU:         fix_res = acc_hi;
            OP_DIV, OP_DIVU:  fix_res = neg_q ? -acc_lo : acc_lo;
            OP_REM, OP_REMU:  fix_res = neg_q ? -acc_hi : acc_hi;
            default:          fix_res = '0;
        endcase
    end

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            alu_res   <= '0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q  <= alu_op;
                        neg_q <= neg_next;
                        if (iter_mul || iter_div) begin
                            acc_hi <= '0;
                            acc_lo <= iter_mul ? s1_mag : s0_mag;
                            opb    <= iter_mul ? s0_mag : s1_mag;
                            cnt    <= '0;
                            state  <= iter_mul ? S_MUL : S_DIV;
                        end else begin
                            alu_res   <= res_comb;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_FIX;
                end
                S_DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_FIX;
                end
                S_FIX: begin
                    alu_res   <= fix_res;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit and an 8-bit instance, directed vectors,
// expected results and completion edges queued at issue and checked by monitors.
module tb_alu_mc;
    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00010, SLT = 5'b00100, SLTU = 5'b00101;
    localparam logic [4:0] AND_ = 5'b01001, OR_ = 5'b01010, XOR_ = 5'b01011, SLL = 5'b01110;
    localparam logic [4:0] SRL = 5'b01111, SRA = 5'b10000, SRC0 = 5'b10001, SRC1 = 5'b10010;
    localparam logic [4:0] MUL = 5'b10100, MULH = 5'b10101, MULHU = 5'b10110;
    localparam logic [4:0] DIV = 5'b11000, DIVU = 5'b11001, REM = 5'b11010, REMU = 5'b11011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  alu_op;
    logic [31:0] alu_src0, alu_src1, alu_res;
    logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [4:0]  alu_op8;
    logic [7:0]  alu_src0_8, alu_src1_8, alu_res8;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1), .out_valid(out_valid),
        .out_ready(out_ready), .alu_res(alu_res), .busy(busy));

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_op(alu_op8), .alu_src0(alu_src0_8), .alu_src1(alu_src1_8), .out_valid(out_valid8),
        .out_ready(out_ready8), .alu_res(alu_res8), .busy(busy8));

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [4:0]  op;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    bit   seen32 = 1'b0, seen8 = 1'b0;
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (q32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out32: got alu_res 0x%0h, required no result", alu_res);
            end else begin
                if (!seen32) begin
                    check($sformatf("latency32 op=%05b", q32[0].op), cyc, q32[0].due);
                    seen32 = 1'b1;
                end
                if (out_ready) begin
                    check($sformatf("result32 op=%05b", q32[0].op), alu_res, q32[0].res);
                    void'(q32.pop_front());
                    seen32 = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && out_valid8) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out8: got alu_res 0x%0h, required no result", alu_res8);
            end else begin
                if (!seen8) begin
                    check($sformatf("latency8 op=%05b", q8[0].op), cyc, q8[0].due);
                    seen8 = 1'b1;
                end
                if (out_ready8) begin
                    check($sformatf("result8 op=%05b", q8[0].op), alu_res8, q8[0].res[7:0]);
                    void'(q8.pop_front());
                    seen8 = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Presents an op, waits (bounded) for in_ready, queues the expectation, crosses the accept edge.
    task automatic issue(input bit w8, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        int   g;
        exp_t e;
        g = 0;
        if (w8) begin
            alu_op8 = op; alu_src0_8 = a[7:0]; alu_src1_8 = b[7:0]; in_valid8 = 1'b1;
        end else begin
            alu_op = op; alu_src0 = a; alu_src1 = b; in_valid = 1'b1;
        end
        #1;
        while (!(w8 ? in_ready8 : in_ready) && g < 100) begin
            step();
            #1;
            g++;
        end
        if (!(w8 ? in_ready8 : in_ready)) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout op=%05b: got in_ready 0, required 1 within 100 cycles", op);
            in_valid = 1'b0;
            in_valid8 = 1'b0;
            step();
            return;
        end
        e.res = res;
        e.due = cyc + lat;
        e.op  = op;
        if (w8) q8.push_back(e);
        else    q32.push_back(e);
        step();
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q32.size() != 0 || q8.size() != 0) && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", q32.size() + q8.size());
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

    logic [4:0]  ops [14];
    logic [31:0] exps[14];
    int          bc;

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; alu_src0 = '0; alu_src1 = '0;
        flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        alu_op8 = '0; alu_src0_8 = '0; alu_src1_8 = '0;

        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_alu_res", alu_res, 0);
        rstn = 1'b1;
        step();
        check("in_ready_after_reset", in_ready, 1);

        // Legacy ops, back to back with src0=0x80000004, src1=0x21.
        ops[0]  = ADD;      exps[0]  = 32'h80000025;
        ops[1]  = SUB;      exps[1]  = 32'h7FFFFFE3;
        ops[2]  = SLT;      exps[2]  = 32'h00000001;
        ops[3]  = SLTU;     exps[3]  = 32'h00000000;
        ops[4]  = AND_;     exps[4]  = 32'h00000000;
        ops[5]  = OR_;      exps[5]  = 32'h80000025;
        ops[6]  = XOR_;     exps[6]  = 32'h80000025;
        ops[7]  = SLL;      exps[7]  = 32'h00000008;
        ops[8]  = SRL;      exps[8]  = 32'h40000002;
        ops[9]  = SRA;      exps[9]  = 32'hC0000002;
        ops[10] = SRC0;     exps[10] = 32'h80000004;
        ops[11] = SRC1;     exps[11] = 32'h00000021;
        ops[12] = 5'b00001; exps[12] = 32'h00000000;
        ops[13] = 5'b11111; exps[13] = 32'h00000000;
        for (int i = 0; i < 14; i++) issue(0, ops[i], 32'h80000004, 32'h00000021, exps[i], 1);
        drain();

        bc = 0;
        issue(0, MUL, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 34);
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            step();
        end
        check("mul_busy_cycles", bc, 33);
        issue(0, MULH,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 34);
        issue(0, MULHU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 34);
        issue(0, DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
        issue(0, REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
        issue(0, DIVU,  32'd100, 32'd7, 32'd14, 34);
        issue(0, REMU,  32'd100, 32'd7, 32'd2, 34);
        issue(0, DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
        issue(0, DIV,   32'd5, 32'd0, 32'hFFFFFFFF, 1);
        issue(0, DIVU,  32'd5, 32'd0, 32'hFFFFFFFF, 1);
        issue(0, REM,   32'h00001234, 32'd0, 32'h00001234, 1);
        issue(0, REMU,  32'h80000000, 32'd0, 32'h80000000, 1);
        issue(0, DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        issue(0, REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        drain();

        // Backpressure, then simultaneous drain and new accept.
        out_ready = 1'b0;
        issue(0, ADD, 32'h80000004, 32'h00000021, 32'h80000025, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_res_stable", alu_res, 32'h80000025);
            check("bp_in_ready_low", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        issue(0, SUB, 32'h80000004, 32'h00000021, 32'h7FFFFFE3, 1);
        drain();

        // Flush at iteration 10 of a DIV, with an ADD presented in the flush cycle.
        issue(0, DIV, 32'd100, 32'd7, 32'd14, 34);
        for (int i = 0; i < 10; i++) step();
        void'(q32.pop_back());
        flush = 1'b1;
        alu_op = ADD; alu_src0 = 32'd1; alu_src1 = 32'd2; in_valid = 1'b1;
        #1;
        check("flush_blocks_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_div_out_valid", out_valid, 0);
        check("flush_div_busy", busy, 0);
        check("flush_div_in_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) step();
        issue(0, ADD, 32'h00000005, 32'h00000007, 32'h0000000C, 1);
        drain();

        // Flush during FIX.
        issue(0, MULHU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 34);
        for (int i = 0; i < 32; i++) step();
        check("fix_busy", busy, 1);
        void'(q32.pop_back());
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_fix_out_valid", out_valid, 0);
        check("flush_fix_busy", busy, 0);
        for (int i = 0; i < 5; i++) step();

        // WIDTH=8 instance.
        issue(1, DIVU, 32'hFF, 32'h10, 32'h0F, 10);
        issue(1, MULH, 32'h80, 32'h80, 32'h40, 10);
        issue(1, REM,  32'hF9, 32'h02, 32'hFF, 10);
        issue(1, DIV,  32'h80, 32'hFF, 32'h80, 1);
        issue(1, SRA,  32'h80, 32'h09, 32'hC0, 1);
        drain();

        // Asynchronous reset in the middle of a multiply on both instances.
        issue(0, MUL, 32'h12345678, 32'h00000009, 32'hA3D70A38, 34);
        issue(1, MUL, 32'h13, 32'h05, 32'h5F, 10);
        for (int i = 0; i < 3; i++) step();
        #4;
        void'(q32.pop_back());
        void'(q8.pop_back());
        rstn = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_alu_res", alu_res, 0);
        check("arst_busy8", busy8, 0);
        check("arst_alu_res8", alu_res8, 0);
        #7;
        rstn = 1'b1;
        step();
        #1;
        check("in_ready_after_arst", in_ready, 1);
        check("in_ready8_after_arst", in_ready8, 1);
        issue(0, MUL, 32'h12345678, 32'h00000009, 32'hA3D70A38, 34);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute ALU.
- Covers every existing ALU operation with the existing 5-bit encodings.
- Adds iterative multiply, divide and remainder.
- Operands arrive on a valid/ready handshake; results leave on a registered valid/ready handshake.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid instead of assuming single-cycle completion.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, log2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort of the in-flight op and the pending result.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept an op this cycle.
- alu_op  in  5  operation code.
- alu_src0  in  WIDTH  operand 0 (rs1 / dividend / multiplicand).
- alu_src1  in  WIDTH  operand 1 (rs2 / divisor / multiplier / shift amount).
- out_valid  out  1  alu_res holds a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- alu_res  out  WIDTH  registered result.
- busy  out  1  iterative op in progress.

Behaviour:
- Opcodes kept unchanged from the single-cycle ALU:
  - ADD 00000, SUB 00010, SLT 00100, SLTU 00101
  - AND 01001, OR 01010, XOR 01011
  - SLL 01110, SRL 01111, SRA 10000
  - SRC0 10001, SRC1 10010
- New opcodes: MUL 10100 (low half), MULH 10101 (signed x signed, high half), MULHU 10110 (unsigned high half), DIV 11000, DIVU 11001, REM 11010, REMU 11011. Any other code returns 0.
- Shifts use alu_src1[SHW-1:0]. SLT/SLTU zero-extend the 1-bit compare result to WIDTH.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Combinational, no dependency on in_valid.
- Single-cycle class (existing ops, undefined codes, div-by-zero, signed overflow): alu_res loaded and out_valid set at the accept edge, so latency is 1. Back-to-back issue is allowed when out_ready=1.
- Iterative ops run through an FSM:
  - IDLE -> MUL or DIV on accept.
  - MUL/DIV run exactly WIDTH iteration cycles, counter 0..WIDTH-1.
  - Then FIX, 1 cycle: sign correction and high/low select; alu_res loaded.
  - Then back to IDLE.
  - Latency = WIDTH+2 edges from accept to out_valid (34 for WIDTH=32).
- Multiplier: radix-2 shift-add on operand magnitudes, 2*WIDTH product register. MULH negates the product in FIX when the sign bits differ. MUL result is identical for signed and unsigned operands.
- Divider: radix-2 restoring on magnitudes.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Special cases, decided at accept, single-cycle class:
  - divisor==0: DIV/DIVU return all-ones; REM/REMU return alu_src0.
  - DIV with src0 = most-negative and src1 = -1: returns src0. REM in the same case returns 0.
- Operands are latched at accept. Input changes during busy have no effect.
- busy = state is MUL, DIV or FIX.
- out_valid stays high and alu_res stays stable until out_ready. An FSM in FIX with out_valid still pending cannot occur, because accept requires the output slot free.
- flush: state -> IDLE, out_valid -> 0, counter cleared. An op presented the same cycle is not accepted. flush overrides completion in the same cycle.
- Reset (rstn=0, any time, including mid-iteration): state=IDLE, out_valid=0, alu_res=0, busy=0, counter=0. in_ready rises in the first cycle after rstn deasserts.

Test Plan:
- Every existing op with WIDTH=32, src0=0x80000004, src1=0x00000021 -> ADD 0x80000025, SUB 0x7FFFFFE3, SLT 1, SLTU 0, SLL 0x00000008, SRA 0xC0000002, SRC1 0x00000021; each with out_valid exactly 1 edge after accept.
- MUL/MULH/MULHU with 0xFFFFFFFE x 0x00000003 -> 0xFFFFFFFA / 0xFFFFFFFF / 0x00000002; out_valid at edge 34; busy high edges 1..33.
- DIV/REM -7 / 2 -> 0xFFFFFFFD / 0xFFFFFFFF; DIVU 100/7 -> 14, REMU 2; divide by 0 -> 0xFFFFFFFF and src0 in 1 cycle; 0x80000000 / -1 -> 0x80000000, REM 0.
- Backpressure: out_ready=0 for 5 cycles after result -> alu_res stable, in_ready=0; out_ready=1 with a new in_valid the same cycle -> both transfers occur, no bubble.
- flush at iteration 10 of a DIV -> out_valid stays 0, in_ready=1 next cycle, next ADD correct; flush in the FIX cycle -> no result emitted.
- rstn pulse mid-MUL (asynchronous, not clock-aligned) -> all outputs 0 immediately; a repeat with WIDTH=8 checks parametrisation, e.g. DIVU 0xFF/0x10 -> 0x0F with out_valid at edge 10.
